// File: rtl/dma_priority_arbiter.sv
// DREQ/DACK priority arbiter for the DMA controller: synchronises requests, picks a
// winner (fixed or rotating), runs the HRQ/HLDA handshake and holds DACK until service ends.
module dma_priority_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              dreq_active_low,
    input  logic              dack_active_low,
    input  logic              rotating_pri,
    input  logic              ctrl_disable,
    input  logic              mask_wr,
    input  logic [NUM_CH-1:0] mask_data,
    input  logic [NUM_CH-1:0] sw_req_set,
    input  logic              HLDA,
    input  logic              svc_done,
    input  logic              tc,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [CH_W-1:0]   active_ch,
    output logic              ch_valid,
    output logic [NUM_CH-1:0] mask_q,
    output logic [NUM_CH-1:0] sw_req_q
);

    typedef enum logic [1:0] {
        SI,
        SO,
        SA
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] dreq_q;
    logic              hrq_q, hrq_d;
    logic [NUM_CH-1:0] dack_q, dack_d;
    logic [CH_W-1:0]   active_ch_q, active_ch_d;
    logic              ch_valid_q, ch_valid_d;
    logic [CH_W-1:0]   hi_ptr_q, hi_ptr_d;
    logic [NUM_CH-1:0] mask_d;
    logic [NUM_CH-1:0] sw_req_d;

    logic [NUM_CH-1:0] req;
    logic              any_req;
    logic [CH_W-1:0]   win_ch;
    logic              win_found;
    logic [CH_W-1:0]   idx;
    int                start;
    logic              tc_hit;

    assign req     = (dreq_q & ~mask_q) | sw_req_q;
    assign any_req = |req;

    // Walk the channels starting at the priority pointer; the first requester wins.
    always_comb begin
        win_ch    = '0;
        win_found = 1'b0;
        idx       = '0;
        start     = rotating_pri ? int'(hi_ptr_q) : 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((start + i) % NUM_CH);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_ch    = idx;
            end
        end
    end

    // NOTE: every variable driven here gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        hrq_d       = hrq_q;
        dack_d      = dack_q;
        active_ch_d = active_ch_q;
        ch_valid_d  = ch_valid_q;
        hi_ptr_d    = hi_ptr_q;
        tc_hit      = 1'b0;
        case (state_q)
            SI: begin
                if (any_req && !ctrl_disable) begin
                    state_d     = SO;
                    hrq_d       = 1'b1;
                    ch_valid_d  = 1'b1;
                    active_ch_d = win_ch;
                end
            end
            SO: begin
                if (!any_req) begin
                    state_d    = SI;
                    hrq_d      = 1'b0;
                    ch_valid_d = 1'b0;
                end else if (HLDA) begin
                    state_d = SA;
                    dack_d  = NUM_CH'(1) << active_ch_q;
                end else begin
                    active_ch_d = win_ch;
                end
            end
            SA: begin
                if (svc_done) begin
                    state_d    = SI;
                    hrq_d      = 1'b0;
                    dack_d     = '0;
                    ch_valid_d = 1'b0;
                    tc_hit     = tc;
                    if (rotating_pri) begin
                        hi_ptr_d = (active_ch_q == CH_W'(NUM_CH - 1)) ? '0 : active_ch_q + 1'b1;
                    end
                end else if (!HLDA) begin
                    // Bus master withdrew the hold: abandon service without rotation or TC effects.
                    state_d    = SI;
                    hrq_d      = 1'b0;
                    dack_d     = '0;
                    ch_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = SI;
                hrq_d      = 1'b0;
                dack_d     = '0;
                ch_valid_d = 1'b0;
            end
        endcase
    end

    // Mask load happens before the TC bit is ORed in; a software set beats the TC clear.
    always_comb begin
        mask_d   = mask_wr ? mask_data : mask_q;
        sw_req_d = sw_req_q;
        if (tc_hit) begin
            mask_d[active_ch_q]   = 1'b1;
            sw_req_d[active_ch_q] = 1'b0;
        end
        sw_req_d = sw_req_d | sw_req_set;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= SI;
            dreq_q      <= '0;
            hrq_q       <= 1'b0;
            dack_q      <= '0;
            active_ch_q <= '0;
            ch_valid_q  <= 1'b0;
            hi_ptr_q    <= '0;
            mask_q      <= '1;
            sw_req_q    <= '0;
        end else begin
            state_q     <= state_d;
            dreq_q      <= DREQ ^ {NUM_CH{dreq_active_low}};
            hrq_q       <= hrq_d;
            dack_q      <= dack_d;
            active_ch_q <= active_ch_d;
            ch_valid_q  <= ch_valid_d;
            hi_ptr_q    <= hi_ptr_d;
            mask_q      <= mask_d;
            sw_req_q    <= sw_req_d;
        end
    end

    assign HRQ       = hrq_q;
    assign DACK      = dack_q ^ {NUM_CH{dack_active_low}};
    assign active_ch = active_ch_q;
    assign ch_valid  = ch_valid_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scoreboard bench for dma_priority_arbiter: a 4-channel instance for the arbitration
// scenarios and an 8-channel instance for reset in the middle of a service.
module tb_dma_priority_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] dreq;
    logic       dreq_active_low;
    logic       dack_active_low;
    logic       rotating_pri;
    logic       ctrl_disable;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic [3:0] sw_req_set;
    logic       hlda;
    logic       svc_done;
    logic       tc;
    logic       hrq;
    logic [3:0] dack;
    logic [1:0] active_ch;
    logic       ch_valid;
    logic [3:0] mask_q;
    logic [3:0] sw_req_q;

    logic [7:0] dreq8;
    logic       mask_wr8;
    logic [7:0] mask_data8;
    logic       hlda8;
    logic       hrq8;
    logic [7:0] dack8;
    logic [2:0] active_ch8;
    logic       ch_valid8;
    logic [7:0] mask_q8;
    logic [7:0] sw_req_q8;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    dma_priority_arbiter #(.NUM_CH(4)) dut (
        .CLK(clk), .RESET_N(rst_n), .DREQ(dreq),
        .dreq_active_low(dreq_active_low), .dack_active_low(dack_active_low),
        .rotating_pri(rotating_pri), .ctrl_disable(ctrl_disable),
        .mask_wr(mask_wr), .mask_data(mask_data), .sw_req_set(sw_req_set),
        .HLDA(hlda), .svc_done(svc_done), .tc(tc),
        .HRQ(hrq), .DACK(dack), .active_ch(active_ch), .ch_valid(ch_valid),
        .mask_q(mask_q), .sw_req_q(sw_req_q)
    );

    dma_priority_arbiter #(.NUM_CH(8)) dut8 (
        .CLK(clk), .RESET_N(rst_n), .DREQ(dreq8),
        .dreq_active_low(1'b0), .dack_active_low(1'b0),
        .rotating_pri(1'b0), .ctrl_disable(1'b0),
        .mask_wr(mask_wr8), .mask_data(mask_data8), .sw_req_set(8'h00),
        .HLDA(hlda8), .svc_done(1'b0), .tc(1'b0),
        .HRQ(hrq8), .DACK(dack8), .active_ch(active_ch8), .ch_valid(ch_valid8),
        .mask_q(mask_q8), .sw_req_q(sw_req_q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hrq(input string tag);
        int cyc = 0;
        while (!hrq && cyc < 20) begin
            tick();
            cyc++;
        end
        check(tag, 32'(hrq), 1);
    endtask

    // Grant the bus, compare against the next scoreboard entry, then finish the service.
    task automatic serve(input logic tc_in, input logic [3:0] dreq_after,
                         input logic [3:0] sw_after, input logic mwr, input logic [3:0] mdata);
        int         exp_ch;
        logic [3:0] oh;
        wait_hrq("hrq_wait");
        hlda = 1'b1;
        tick();
        check("sb_nonempty", 32'(exp_q.size() > 0), 1);
        exp_ch = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        oh     = 4'b0001 << exp_ch;
        check("sa_active_ch", 32'(active_ch), 32'(exp_ch));
        check("sa_dack", 32'(dack), 32'(oh ^ {4{dack_active_low}}));
        check("sa_ch_valid", 32'(ch_valid), 1);
        svc_done   = 1'b1;
        tc         = tc_in;
        dreq       = dreq_after;
        sw_req_set = sw_after;
        mask_wr    = mwr;
        mask_data  = mdata;
        hlda       = 1'b0;
        tick();
        svc_done   = 1'b0;
        tc         = 1'b0;
        sw_req_set = 4'b0000;
        mask_wr    = 1'b0;
        check("done_dack", 32'(dack), 32'({4{dack_active_low}}));
        check("done_hrq", 32'(hrq), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        dreq = '0; dreq_active_low = 1'b0; dack_active_low = 1'b0;
        rotating_pri = 1'b0; ctrl_disable = 1'b0;
        mask_wr = 1'b0; mask_data = '0; sw_req_set = '0;
        hlda = 1'b0; svc_done = 1'b0; tc = 1'b0;
        dreq8 = '0; mask_wr8 = 1'b0; mask_data8 = '0; hlda8 = 1'b0;
        tick();
        tick();
        check("rst_hrq", 32'(hrq), 0);
        check("rst_dack", 32'(dack), 0);
        check("rst_active_ch", 32'(active_ch), 0);
        check("rst_ch_valid", 32'(ch_valid), 0);
        check("rst_mask", 32'(mask_q), 32'h0000000F);
        check("rst_sw_req", 32'(sw_req_q), 0);
        rst_n = 1'b1;

        // Fixed priority, unmasked: ch1 then ch2.
        mask_wr = 1'b1; mask_data = 4'b0000;
        tick();
        mask_wr = 1'b0;
        check("mask_load", 32'(mask_q), 0);
        dreq = 4'b0110;
        exp_q.push_back(1);
        tick();
        check("hrq_lat1", 32'(hrq), 0);
        tick();
        check("hrq_lat2", 32'(hrq), 1);
        check("so_active_ch", 32'(active_ch), 1);
        check("so_ch_valid", 32'(ch_valid), 1);
        check("so_dack_idle", 32'(dack), 0);
        serve(1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000);
        exp_q.push_back(2);
        serve(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);

        // A disabled controller starts no new arbitration.
        ctrl_disable = 1'b1;
        dreq = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        check("disable_hrq", 32'(hrq), 0);
        ctrl_disable = 1'b0;
        exp_q.push_back(0);
        serve(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);

        // Rotating: ch1, then all four requesting -> 2,3,0,1.
        rotating_pri = 1'b1;
        dreq = 4'b0010;
        exp_q.push_back(1);
        serve(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000);
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
        for (int i = 0; i < 3; i++) serve(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000);
        serve(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);

        // Preemption in SO (fixed), then an abort in SA.
        rotating_pri = 1'b0;
        dreq = 4'b0100;
        wait_hrq("pre_hrq");
        check("pre_active_ch", 32'(active_ch), 2);
        dreq = 4'b0101;
        tick();
        tick();
        check("preempt_active_ch", 32'(active_ch), 0);
        hlda = 1'b1;
        tick();
        check("preempt_dack", 32'(dack), 32'h1);
        hlda = 1'b0;
        dreq = 4'b0000;
        tick();
        check("abort_dack", 32'(dack), 0);
        check("abort_hrq", 32'(hrq), 0);
        check("abort_ch_valid", 32'(ch_valid), 0);

        // Abort in rotating mode must leave the pointer (at 2) untouched.
        rotating_pri = 1'b1;
        dreq = 4'b1111;
        wait_hrq("rot_hrq");
        check("rot_start_ch", 32'(active_ch), 2);
        hlda = 1'b1;
        tick();
        hlda = 1'b0;
        tick();
        check("rot_abort_hrq", 32'(hrq), 0);
        wait_hrq("rot_rehrq");
        check("hi_ptr_kept", 32'(active_ch), 2);
        exp_q.push_back(2);
        serve(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);

        // Software request through a full mask, then TC auto-mask.
        rotating_pri = 1'b0;
        mask_wr = 1'b1; mask_data = 4'b1111; dreq = 4'b1111;
        tick();
        mask_wr = 1'b0;
        sw_req_set = 4'b1000;
        tick();
        sw_req_set = 4'b0000;
        check("sw_req_set", 32'(sw_req_q), 32'h8);
        check("sw_hrq_lat1", 32'(hrq), 0);
        tick();
        check("sw_hrq_lat2", 32'(hrq), 1);
        exp_q.push_back(3);
        serve(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000);
        check("tc_sw_clear", 32'(sw_req_q), 0);
        check("tc_mask_all", 32'(mask_q), 32'hF);
        for (int i = 0; i < 3; i++) tick();
        check("tc_hrq_quiet", 32'(hrq), 0);

        // TC together with mask_wr and a software set on the same channel.
        mask_wr = 1'b1; mask_data = 4'b0000; dreq = 4'b0100;
        tick();
        mask_wr = 1'b0;
        exp_q.push_back(2);
        serve(1'b1, 4'b0000, 4'b0100, 1'b1, 4'b0001);
        check("tc_mask_merge", 32'(mask_q), 32'h5);
        check("tc_set_wins", 32'(sw_req_q), 32'h4);
        exp_q.push_back(2);
        serve(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        check("tc2_sw_clear", 32'(sw_req_q), 0);
        check("tc2_mask", 32'(mask_q), 32'h5);

        // Active-low DREQ and DACK.
        mask_wr = 1'b1; mask_data = 4'b0000;
        dreq_active_low = 1'b1; dack_active_low = 1'b1; dreq = 4'b1011;
        tick();
        mask_wr = 1'b0;
        check("pol_dack_idle", 32'(dack), 32'hF);
        exp_q.push_back(2);
        serve(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000);
        rst_n = 1'b0;
        #1;
        check("pol_rst_dack", 32'(dack), 32'hF);
        check("pol_rst_mask", 32'(mask_q), 32'hF);
        tick();
        rst_n = 1'b1;
        dreq_active_low = 1'b0; dack_active_low = 1'b0; dreq = 4'b0000;

        // 8 channels: reset while ch7 is being served.
        mask_wr8 = 1'b1; mask_data8 = 8'h00;
        tick();
        mask_wr8 = 1'b0;
        dreq8 = 8'h80;
        begin
            int cyc = 0;
            while (!hrq8 && cyc < 20) begin
                tick();
                cyc++;
            end
        end
        check("ch8_hrq", 32'(hrq8), 1);
        check("ch8_active_ch", 32'(active_ch8), 7);
        hlda8 = 1'b1;
        tick();
        check("ch8_dack", 32'(dack8), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        check("ch8_rst_hrq", 32'(hrq8), 0);
        check("ch8_rst_dack", 32'(dack8), 0);
        check("ch8_rst_mask", 32'(mask_q8), 32'hFF);
        check("ch8_rst_valid", 32'(ch_valid8), 0);
        check("ch8_rst_active", 32'(active_ch8), 0);
        check("ch8_rst_sw", 32'(sw_req_q8), 0);
        hlda8 = 1'b0;
        dreq8 = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
